// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
package fifo_pkg;

  localparam int unsigned DefaultDataWidth = 256;
  localparam int unsigned DefaultAddrWidth = 7;

  // Bits needed to encode values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module fifo_ram_sdp #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write-first on an address collision so a word written this cycle is
  // already visible as the pre-fetched head on the next one.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with level flags, flush and sticky error flags.
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH    = DefaultAddrWidth,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth    = 2**ADDR_WIDTH;
  localparam int unsigned CntWidth = clog2(Depth + 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc, rd_acc, ram_empty, bypass, ram_we, ram_pop;
  logic [DATA_WIDTH-1:0] ram_rdata;

  fifo_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && valid_q;
    // The RAM holds every stored word except the one in the output register.
    ram_empty = (count_q == CntWidth'(valid_q));
    bypass    = wr_acc && ram_empty && (!valid_q || rd_acc);
    ram_we    = wr_acc && !bypass && !flush && !reset;
    ram_pop   = rd_acc && !ram_empty;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q || (wr_en && full);
    underflow_d = underflow_q || (rd_en && !valid_q);

    if (ram_we)  wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (ram_pop) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    if (ram_pop) begin
      data_out_d = ram_rdata;
      valid_d    = 1'b1;
    end else if (bypass) begin
      data_out_d = data_in;
      valid_d    = 1'b1;
    end else if (rd_acc) begin
      valid_d = 1'b0;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      valid_d     = 1'b0;
      data_out_d  = data_out_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid        = valid_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CntFull);
  assign almost_full  = (32'(count_q) >= AFULL_THRESH);
  assign almost_empty = (32'(count_q) <= AEMPTY_THRESH);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Self-checking bench for fifo_sync_fwft against a queue-based reference model.
module tb_fifo_sync_fwft;

  localparam int unsigned Dw     = 256;
  localparam int unsigned Aw     = 7;
  localparam int unsigned Depth  = 128;
  localparam int unsigned AfullT = 124;
  localparam int unsigned AemptT = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          wr_en;
  logic [Dw-1:0] data_in;
  logic          rd_en;
  logic [Dw-1:0] data_out;
  logic          valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [Aw:0]   count;
  logic          overflow;
  logic          underflow;

  fifo_sync_fwft #(
    .DATA_WIDTH    (Dw),
    .ADDR_WIDTH    (Aw),
    .AFULL_THRESH  (AfullT),
    .AEMPTY_THRESH (AemptT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid        (valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [Dw-1:0] model_q[$];
  logic          exp_ovf;
  logic          exp_unf;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [Dw-1:0] got, input logic [Dw-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = model_q.size();
    chk("valid", valid, Dw'(sz > 0));
    if (sz > 0) chk("data_out", data_out, model_q[0]);
    chk("count", Dw'(count), Dw'(sz));
    chk("empty", empty, Dw'(sz == 0));
    chk("full", full, Dw'(sz == Depth));
    chk("almost_full", almost_full, Dw'(sz >= AfullT));
    chk("almost_empty", almost_empty, Dw'(sz <= AemptT));
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_unf);
  endtask

  // One clock: drive, let the DUT sample, advance the model, then check.
  task automatic cycle(input logic w, input logic [Dw-1:0] d, input logic r,
                       input logic fl, input logic rs);
    bit was_full;
    bit was_valid;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    flush   = fl;
    reset   = rs;
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      was_full  = (model_q.size() == Depth);
      was_valid = (model_q.size() > 0);
      if (w && was_full) exp_ovf = 1'b1;
      if (r && !was_valid) exp_unf = 1'b1;
      if (r && was_valid) void'(model_q.pop_front());
      if (w && !was_full) model_q.push_back(d);
    end
    #1;
    check_all();
  endtask

  function automatic logic [Dw-1:0] rand_word();
    logic [Dw-1:0] v;
    for (int k = 0; k < Dw / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    reset   = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;

    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reset_data_out", data_out, '0);

    // Single word falls through and holds without rd_en.
    cycle(1'b1, Dw'('hA1), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("a1_hold", data_out, Dw'('hA1));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill to full, overflow, then full with rd+wr together.
    for (int i = 0; i < Depth; i++) cycle(1'b1, Dw'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, Dw'('hFF), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, Dw'('hEE), 1'b1, 1'b0, 1'b0);
    chk("full_rdwr_count", Dw'(count), Dw'(127));
    repeat (Depth - 1) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Read on empty.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("underflow_set", underflow, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Steady state at count 5 across several pointer wraps.
    repeat (5) cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    repeat (300) cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0);
    chk("steady_count", Dw'(count), Dw'(5));

    // Flush at count 40 with a concurrent write, then a fresh write.
    repeat (35) cycle(1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, rand_word(), 1'b0, 1'b1, 1'b0);
    chk("flush_count", Dw'(count), '0);
    cycle(1'b1, Dw'('h5), 1'b0, 1'b0, 1'b0);
    chk("post_flush_word", data_out, Dw'('h5));

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 2500; i++) begin
      logic w, r, fl, rs;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 127) == 0);
      rs = ($urandom_range(0, 255) == 0);
      cycle(w, rand_word(), r, fl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
